// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, marks entries done on writeback,
// retires from head and raises a one-cycle flush when a committed branch mispredicted.
package rob_pkg;
  localparam int INT_DATA_W      = 32;
  localparam int INSTR_MEM_IDX_W = 8;

  typedef struct packed {
    logic                       valid;
    logic                       done;
    logic [INT_DATA_W-1:0]      result;
    logic [INSTR_MEM_IDX_W-1:0] pc;
    logic                       is_branch;
    logic                       pred_taken;
    logic [INSTR_MEM_IDX_W-1:0] pred_target;
    logic [4:0]                 rd;
  } rob_entry_t;
endpackage

module reorder_buffer
  import rob_pkg::*;
#(
  parameter int ROB_LENGTH = 16,
  parameter int ROB_IDX_W  = $clog2(ROB_LENGTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_alloc_valid,
  input  rob_entry_t                 i_alloc_entry,
  output logic                       o_alloc_ready,
  output logic [ROB_IDX_W-1:0]       o_alloc_idx,
  input  logic                       i_wb_valid,
  input  logic [ROB_IDX_W-1:0]       i_wb_idx,
  input  logic [INT_DATA_W-1:0]      i_wb_result,
  input  logic                       i_wb_taken,
  input  logic [INSTR_MEM_IDX_W-1:0] i_wb_target,
  output logic                       o_commit_valid,
  input  logic                       i_commit_ready,
  output rob_entry_t                 o_commit_entry,
  output logic [ROB_IDX_W-1:0]       o_commit_idx,
  output logic                       o_flush,
  output logic [INSTR_MEM_IDX_W-1:0] o_flush_pc,
  output logic [ROB_IDX_W:0]         o_count
);

  localparam logic [ROB_IDX_W:0] LP_FULL = ROB_LENGTH[ROB_IDX_W:0];

  rob_entry_t                 r_entries    [ROB_LENGTH];
  logic                       r_act_taken  [ROB_LENGTH];
  logic [INSTR_MEM_IDX_W-1:0] r_act_target [ROB_LENGTH];
  logic [ROB_IDX_W-1:0]       r_head;
  logic [ROB_IDX_W-1:0]       r_tail;
  logic [ROB_IDX_W:0]         r_count;
  logic                       r_flush;
  logic [INSTR_MEM_IDX_W-1:0] r_flush_pc;

  rob_entry_t                 w_head_entry;
  rob_entry_t                 w_alloc_entry;
  logic                       w_head_act_taken;
  logic [INSTR_MEM_IDX_W-1:0] w_head_act_target;
  logic                       w_commit_valid;
  logic                       w_mispredict;
  logic                       w_mp_commit;
  logic                       w_alloc_ready;
  logic                       w_alloc_fire;
  logic                       w_commit_fire;
  logic [INSTR_MEM_IDX_W-1:0] w_redirect_pc;

  always_comb begin
    w_head_entry      = r_entries[r_head];
    w_head_act_taken  = r_act_taken[r_head];
    w_head_act_target = r_act_target[r_head];
    w_commit_valid    = w_head_entry.valid && w_head_entry.done;
    w_mispredict      = w_commit_valid && w_head_entry.is_branch &&
                        ((w_head_act_taken != w_head_entry.pred_taken) ||
                         (w_head_act_taken && (w_head_act_target != w_head_entry.pred_target)));
    w_mp_commit       = w_mispredict && i_commit_ready;
    // No full-queue bypass: a same-cycle commit does not free a slot for alloc.
    w_alloc_ready     = (r_count < LP_FULL) && !r_flush && !w_mp_commit;
    w_alloc_fire      = i_alloc_valid && w_alloc_ready;
    w_commit_fire     = w_commit_valid && i_commit_ready;
    w_redirect_pc     = w_head_act_taken ? w_head_act_target
                                         : w_head_entry.pc + INSTR_MEM_IDX_W'(1);
  end

  always_comb begin
    w_alloc_entry        = i_alloc_entry;
    w_alloc_entry.valid  = 1'b1;
    w_alloc_entry.done   = 1'b0;
    w_alloc_entry.result = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ROB_LENGTH; i++) begin
        r_entries[i]    <= '0;
        r_act_taken[i]  <= 1'b0;
        r_act_target[i] <= '0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_flush    <= 1'b0;
      r_flush_pc <= '0;
    end else begin
      r_flush <= w_mp_commit;
      if (w_mp_commit) begin
        // Mispredicted branch retires; everything younger is discarded.
        for (int i = 0; i < ROB_LENGTH; i++) begin
          r_entries[i].valid <= 1'b0;
          r_entries[i].done  <= 1'b0;
        end
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        r_flush_pc <= w_redirect_pc;
      end else begin
        if (i_wb_valid && r_entries[i_wb_idx].valid) begin
          r_entries[i_wb_idx].done   <= 1'b1;
          r_entries[i_wb_idx].result <= i_wb_result;
          r_act_taken[i_wb_idx]      <= i_wb_taken;
          r_act_target[i_wb_idx]     <= i_wb_target;
        end
        // Later assignment lets alloc override a colliding writeback.
        if (w_alloc_fire) begin
          r_entries[r_tail] <= w_alloc_entry;
          r_tail            <= r_tail + ROB_IDX_W'(1);
        end
        if (w_commit_fire) begin
          r_entries[r_head].valid <= 1'b0;
          r_head                  <= r_head + ROB_IDX_W'(1);
        end
        case ({w_alloc_fire, w_commit_fire})
          2'b10:   r_count <= r_count + (ROB_IDX_W+1)'(1);
          2'b01:   r_count <= r_count - (ROB_IDX_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign o_alloc_ready  = w_alloc_ready;
  assign o_alloc_idx    = r_tail;
  assign o_commit_valid = w_commit_valid;
  assign o_commit_entry = w_head_entry;
  assign o_commit_idx   = r_head;
  assign o_flush        = r_flush;
  assign o_flush_pc     = r_flush_pc;
  assign o_count        = r_count;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement queue of the out-of-order posit core. Built on the shared `rob_entry_t` entry type.
- Sits between rename/dispatch (allocation) and architectural commit; the execution units' writeback marks entries done.
- Retires one instruction per cycle in program order.
- Detects branch mispredicts at commit and issues a full pipeline flush with the corrected PC.

Parameters:
- ROB_LENGTH, 16, number of entries; must be a power of two, ≥2.
- ROB_IDX_W, $clog2(ROB_LENGTH), entry tag width.
- INT_DATA_W, 32, result width.
- INSTR_MEM_IDX_W, 8, PC width; PC is an instruction index.

Ports:
- clk  in  1  single core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  dispatch presents an instruction.
- alloc_entry  in  $bits(rob_entry_t)  entry fields; valid/done/result ignored.
- alloc_ready  out  1  entry can be accepted this cycle.
- alloc_idx  out  ROB_IDX_W  tag of the slot being allocated (= tail).
- wb_valid  in  1  execution-unit completion.
- wb_idx  in  ROB_IDX_W  tag of the completing entry.
- wb_result  in  INT_DATA_W  result value.
- wb_taken  in  1  actual branch direction (branches only).
- wb_target  in  INSTR_MEM_IDX_W  actual branch target (branches only).
- commit_valid  out  1  head entry is retireable.
- commit_ready  in  1  commit stage accepts head.
- commit_entry  out  $bits(rob_entry_t)  head entry contents.
- commit_idx  out  ROB_IDX_W  head tag.
- flush  out  1  one-cycle mispredict flush pulse.
- flush_pc  out  INSTR_MEM_IDX_W  redirect PC, valid while flush=1.
- count  out  ROB_IDX_W+1  occupied entries.

Behaviour:
- State: head, tail (ROB_IDX_W); count; per-entry rob_entry_t; per-entry act_taken and act_target.
- Reset: all entry valid/done=0; head=tail=count=0; flush=0; flush_pc=0. Resulting outputs: alloc_ready=1, commit_valid=0. Reset mid-operation discards all entries with no flush pulse.
- alloc_ready = (count<ROB_LENGTH) && !flush && !head_mispredict_commit. There is no same-cycle bypass: when full, a commit in the same cycle does not enable alloc.
- Alloc fire (alloc_valid && alloc_ready):
  - entry[tail] ← alloc_entry with valid=1, done=0, result=0.
  - tail ← tail+1, wrapping ROB_LENGTH-1 → 0.
  - alloc_idx is combinational from tail.
- Writeback: if wb_valid and entry[wb_idx].valid, set done=1, result=wb_result, act_taken=wb_taken, act_target=wb_target at the edge. Writeback to an invalid entry is ignored. Writeback order is arbitrary.
- commit_valid = entry[head].valid && entry[head].done, from registered state only. commit_entry and commit_idx reflect head.
- Commit fire (commit_valid && commit_ready): entry[head].valid ← 0; head ← head+1 with wrap.
- count ← count + alloc_fire − commit_fire.
- Mispredict: head_mispredict = commit_valid && is_branch && (act_taken≠pred_taken || (act_taken && act_target≠pred_target)).
  - head_mispredict_commit = head_mispredict && commit_ready.
- On mispredict commit fire:
  - The branch itself retires normally (commit_valid=1 that cycle).
  - At the edge, all entries are invalidated and head=tail=count=0.
  - Same-cycle allocs and writebacks are dropped.
  - Next cycle: flush=1 for exactly one cycle; flush_pc = act_taken ? act_target : pc+1, modulo 2^INSTR_MEM_IDX_W.
  - alloc_ready=0 during the flush cycle.
- Simultaneous alloc and writeback to the same idx cannot occur legitimately; if it does, alloc wins.
- Simultaneous alloc and commit at count=1: both take effect, count stays 1.
- Empty (count=0): commit_valid=0, and writebacks are ignored because all entries are invalid.

Test Plan:
- Reset, then 16 back-to-back allocs with commit_ready=0 → alloc_idx 0..15; count=16; alloc_ready=0 on the 17th cycle.
- Alloc 3 entries; writeback idx 2, 0, 1 on successive cycles with result=idx+100; commit_ready=1 → commits idx 0, 1, 2 in order with results 100, 101, 102; count returns to 0.
- Entry 0 done, commit_ready=0 for 4 cycles → commit_valid held at 1, head stays 0; retires on the first cycle commit_ready=1.
- Branch at idx 1, pc=0x20, pred_taken=0; wb_taken=1, wb_target=0x40; entries 2–5 allocated → idx 1 commits; next cycle flush=1, flush_pc=0x40; count=0; the alloc attempted in the commit cycle is lost. Repeat with pred_taken=1, pred_target=0x40, wb_taken=0 → flush_pc=0x21.
- Correctly predicted branch (taken, target match) → no flush; following entries retire normally.
- Wrap-around: run 40 alloc/commit pairs at occupancy 1–3 → tags wrap 15→0; commit order is preserved. A writeback to an invalidated idx changes no state.
